// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit, 7-segment display.
// Each digit slot is TICKS_PER_DIGIT clocks long. It starts with BLANK_TICKS
// clocks with all anodes off, which suppresses ghosting. ON_TICKS clocks of
// PWM-dimmed on-time follow. The on-time is split into eight equal steps, and
// bright+1 of them are lit.
//
// New display data is loaded into a shadow set. It is copied to the active set
// only on the first cycle of a digit-0 slot, so a frame never mixes old and new
// digits.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   load           one-cycle strobe capturing value/dp_in/lz_blank into shadow
//   value[15:0]    four hex digits, value[3:0] is digit 0 (rightmost)
//   dp_in[3:0]     decimal point per digit, 1 = lit
//   lz_blank       1 = blank leading zeros
//   bright[2:0]    brightness, 0 = dimmest, 7 = full on-time (sampled live)
//   an[3:0]        anode enables, active-low
//   seg[6:0]       cathodes {g,f,e,d,c,b,a}, active-low
//   dp             decimal-point cathode, active-low
//   digit_sel[1:0] index of the slot the outputs currently belong to
//   update_pending shadow holds data not yet displayed
//   frame_start    one-cycle pulse on the first cycle of each digit-0 slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    input  logic [2:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        update_pending,
    output logic        frame_start
);

    localparam int ON_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
    localparam int ON_STEP  = ON_TICKS / 8;
    localparam int CNT_MAX  = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);

    generate
        if (ON_TICKS < 8 || (ON_TICKS % 8) != 0 || BLANK_TICKS < 1) begin : g_bad_params
            $error("seg_scan_ctrl: ON_TICKS must be >= 8 and a multiple of 8, BLANK_TICKS >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Scan state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;

    // Shadow and active display sets
    logic [15:0] sh_value_q, sh_value_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic        sh_lz_q, sh_lz_d;
    logic [15:0] act_value_q, act_value_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic        act_lz_q, act_lz_d;
    logic        pending_q, pending_d;

    // Registered outputs
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic       frame_start_q, frame_start_d;

    // Helper signals
    logic        frame_edge;
    logic        commit;
    logic [3:0]  digit_blank;
    logic [3:0]  cur_nibble;
    logic [31:0] on_limit;
    logic        on_window;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The first cycle of the digit-0 slot marks the frame boundary. That is
    // the only place where the shadow set may be copied to the active set.
    assign frame_edge = (state_q == ST_BLANK) && (cnt_q == '0) && (dig_q == 2'd0);
    assign commit     = frame_edge && pending_q;

    // A digit is a leading zero when it and every higher nibble are zero.
    // Digit 0 always shows, so a value of zero still displays "0".
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_rightmost
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign digit_blank[gi] = act_lz_q && (act_value_q[15:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_nibble = act_value_q[{dig_q, 2'b00} +: 4];
    assign on_limit   = (32'(bright) + 32'd1) * 32'(ON_STEP);
    assign on_window  = (state_q == ST_ON) && (32'(cnt_q) < on_limit) && !digit_blank[dig_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        dig_d   = dig_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    dig_d   = dig_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // A load on the commit cycle still lands in the shadow set. The active
        // set takes the previous shadow contents, so the new data stays pending.
        sh_value_d  = load ? value    : sh_value_q;
        sh_dp_d     = load ? dp_in    : sh_dp_q;
        sh_lz_d     = load ? lz_blank : sh_lz_q;
        act_value_d = commit ? sh_value_q : act_value_q;
        act_dp_d    = commit ? sh_dp_q    : act_dp_q;
        act_lz_d    = commit ? sh_lz_q    : act_lz_q;
        pending_d   = load | (pending_q & ~commit);

        // Output registers lag the scan state by one cycle. Digit changes happen
        // only while the anodes are already off, so digits never overlap.
        an_d = 4'b1111;
        if (on_window) begin
            an_d[dig_q] = 1'b0;
        end
        seg_d         = digit_blank[dig_q] ? 7'b1111111 : hex_seg(cur_nibble);
        dp_d          = on_window ? ~act_dp_q[dig_q] : 1'b1;
        digit_sel_d   = dig_q;
        frame_start_d = frame_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            dig_q         <= 2'd0;
            sh_value_q    <= '0;
            sh_dp_q       <= '0;
            sh_lz_q       <= 1'b0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_lz_q      <= 1'b0;
            pending_q     <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
            digit_sel_q   <= 2'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            sh_value_q    <= sh_value_d;
            sh_dp_q       <= sh_dp_d;
            sh_lz_q       <= sh_lz_d;
            act_value_q   <= act_value_d;
            act_dp_q      <= act_dp_d;
            act_lz_q      <= act_lz_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an             = an_q;
    assign seg            = seg_q;
    assign dp             = dp_q;
    assign digit_sel      = digit_sel_q;
    assign update_pending = pending_q;
    assign frame_start    = frame_start_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit, 7-segment display. It takes a 16-bit hex value, four decimal points and a brightness level, then drives the digits one at a time. Each digit gets a ghost-suppression blank interval and a PWM-dimmed on interval. Display updates are double-buffered and applied only at frame boundaries, so digits never tear. The refresh timebase is generated internally as a clock-enable prescaler, not a derived clock.

## Interface
- TICKS_PER_DIGIT, 50000, clk cycles per digit slot (blank + on).
- BLANK_TICKS, 2000, cycles at the start of each slot with all anodes off.
- Elaboration requirements: ON_TICKS = TICKS_PER_DIGIT − BLANK_TICKS must be ≥ 8 and a multiple of 8. BLANK_TICKS must be ≥ 1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle strobe; captures value, dp_in and lz_blank into the shadow register.
- value  in  16  hex digits. value[3:0] is digit 0 (rightmost) and value[15:12] is digit 3.
- dp_in  in  4  decimal point per digit, 1 = lit; bit i maps to digit i.
- lz_blank  in  1  1 = blank leading zeros.
- bright  in  3  brightness; 0 = dimmest, 7 = full on-time.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- seg  out  7  cathodes, active-low; seg[0] = a … seg[6] = g.
- dp  out  1  decimal-point cathode, active-low.
- digit_sel  out  2  index of the current slot.
- update_pending  out  1  shadow holds data not yet displayed.
- frame_start  out  1  one-cycle pulse on the first cycle of each digit-0 slot.

## Operation
- **Registers.** One shadow register set (value, dp, lz_blank) and one active register set. The display always renders the active set.
- **Load.** On `load`, the shadow set captures its inputs and update_pending is set to 1. A second load while pending overwrites the shadow; the last load wins.
- **FSM states.** BLANK → ON → (advance digit_sel) → BLANK.
  - BLANK lasts BLANK_TICKS cycles. During BLANK, an = 4'b1111, and seg/dp are precomputed for the current digit_sel.
  - ON lasts ON_TICKS cycles, counted by on_cnt from 0 to ON_TICKS−1. During ON, an[digit_sel] = 0 only while on_cnt < (bright+1)·(ON_TICKS/8). For all other on_cnt values, an = 4'b1111.
- **Slot advance and frame wrap.** At the end of ON, digit_sel increments modulo 4. On the 3→0 wrap, if update_pending is set, the active set is loaded from the shadow and update_pending is cleared.
- **Simultaneous load and wrap.** The active set takes the shadow contents from before this cycle. The shadow takes the new inputs. update_pending stays 1.
- **Segment decode.** Standard hex, active-low, written as {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110.
- **Leading-zero blanking.** Applies when lz_blank is set in the active set. Digit i ∈ {3,2,1} is blanked when its nibble and every higher nibble are zero. Digit 0 is never blanked. A blanked digit keeps its anode high for the whole slot. The dp of a blanked digit is not shown.
- **Decimal point.** dp = ~active_dp[digit_sel] while the anode is enabled; otherwise dp = 1.
- **Brightness.** bright is sampled live, with no buffering.

## Timing
- **Reset.** The outputs reset asynchronously, immediately on rst_n low:
  - an = 4'b1111, seg = 7'b1111111, dp = 1
  - digit_sel = 0, update_pending = 0, frame_start = 0
  - active and shadow sets = 0
  - FSM in BLANK with its counter at 0
- **First cycle after reset.** On the first posedge after rst_n rises, frame_start = 1.
- **Frame period.** Exactly 4·TICKS_PER_DIGIT cycles. frame_start pulses every frame, including frames with no update.
- **Output latency.** an, seg and dp are registered and change one cycle after the FSM/counter state that selects them. The blank interval therefore starts on the same edge as the slot boundary, and there is no overlap between digits.
- **Load visibility.** A load is first visible at the next frame_start. update_pending falls on the same edge on which frame_start rises.
- **Reset mid-slot.** All outputs are forced off within the same cycle. No partial frame is completed.

## Test plan
Parameters for all scenarios: TICKS_PER_DIGIT=24, BLANK_TICKS=8 (ON_TICKS=16).

- **Reset and idle frames.** Assert rst_n=0 mid-ON with bright=7.
  - an=1111, seg=1111111 and dp=1 within the same cycle.
  - After release: frame_start at cycle 1, then every 96 cycles. digit_sel steps 0,1,2,3 every 24 cycles.
  - All digits show seg=1000000.
- **Hex decode and decimal point.** Load 16'h1A08 with dp_in=4'b0100 and bright=7. In the next frame:
  - digit0 seg=0000000
  - digit1 seg=1000000
  - digit2 seg=0001000 with dp=0
  - digit3 seg=1111001
  - In each slot, an is low for exactly 16 cycles after 8 cycles high.
- **Mid-frame load.** Load 16'hFFFF while digit 1 is showing 16'h0000.
  - update_pending goes to 1.
  - Digits 2 and 3 still show 0.
  - update_pending falls together with the next frame_start, and digit 0 then shows 0001110.
- **Leading-zero blanking.** Load 16'h0050 with lz_blank=1.
  - an[3] and an[2] stay high throughout their slots.
  - digit1 shows 0010010 and digit0 shows 1000000.
  - Loading 16'h0000 with lz_blank=1 leaves only digit 0 lit, showing 0.
- **Brightness.** With bright=1, an[digit_sel] is low for exactly 4 cycles (on_cnt 0–3) per slot. With bright=0, it is low for 2 cycles.
- **Load on the wrap cycle.**
  - Load A on an earlier cycle.
  - Load B on the exact 3→0 wrap cycle.
  - The new frame shows A, update_pending remains 1, and B appears at the following frame_start.
